// File: rtl/logic_block_pkg.sv
// rtl/logic_block_pkg.sv - shared constants and helpers for the LUT logic cell
package logic_block_pkg;

  // Fabric-wide LUT input count.
  localparam int LUT_K = 2;

  // Truth-table width for a K-input LUT.
  function automatic int lut_width(input int k);
    return 1 << k;
  endfunction

endpackage

// File: rtl/logic_block_lut_mux.sv
// rtl/logic_block_lut_mux.sv - parameterised 2**K:1 truth-table multiplexer
module lut_mux
  import logic_block_pkg::*;
#(
  parameter int K = LUT_K
) (
  input  logic [K-1:0]            sel,
  input  logic [lut_width(K)-1:0] mem,
  output logic                    lut_val
);

  // Pure mux: the select inputs index straight into the truth table, so no state is inferred.
  always_comb begin
    lut_val = mem[sel];
  end

endmodule

// File: rtl/logic_block.sv
// rtl/logic_block.sv - two-input LUT cell with optional synchronous-reset output register
module logic_block
  import logic_block_pkg::*;
#(
  parameter int K = LUT_K
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [K-1:0]            in,
  input  logic [lut_width(K)-1:0] mem,
  input  logic                    sync,
  output logic                    out
);

  logic lut_val;
  logic q_d;
  logic q_q;

  lut_mux #(
    .K (K)
  ) u_lut_mux (
    .sel     (in),
    .mem     (mem),
    .lut_val (lut_val)
  );

  // Next register value: the register tracks the LUT in both modes so a mode switch shows a fresh capture.
  always_comb begin
    q_d = lut_val;
  end

  // Output register with synchronous active-low clear; reset wins over any input change at the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  // Output select: combinational LUT value or the registered copy.
  always_comb begin
    out = sync ? q_q : lut_val;
  end

endmodule

// File: tb/tb_logic_block.sv
// tb/tb_logic_block.sv - self-checking bench for logic_block
module tb_logic_block;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sync;
  logic [1:0] in_v;
  logic [3:0] mem_v;
  logic       out;

  int   checks = 0;
  int   errors = 0;
  logic model_q = 1'b0;

  always #5 clk = ~clk;

  logic_block #(.K(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (in_v),
    .mem   (mem_v),
    .sync  (sync),
    .out   (out)
  );

  // Truth-table lookup by shifting the configuration word right by the input value.
  function automatic logic ref_lut(input logic [3:0] m, input logic [1:0] i);
    logic [3:0] shifted;
    shifted = m >> i;
    return (shifted & 4'd1) != 4'd0;
  endfunction

  function automatic logic ref_out();
    return sync ? model_q : ref_lut(mem_v, in_v);
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, update the register model from the inputs present at that edge.
  task automatic tick();
    @(posedge clk);
    model_q = rst_n ? ref_lut(mem_v, in_v) : 1'b0;
    #1;
  endtask

  int   exp_tab [3][4] = '{'{0, 0, 0, 1}, '{0, 1, 1, 1}, '{0, 1, 1, 0}};
  logic [3:0] cfg_tab [3] = '{4'b1000, 4'b1110, 4'b0110};
  logic prev;

  initial begin
    // Reset in registered mode.
    rst_n = 1'b0; sync = 1'b1; in_v = 2'b11; mem_v = 4'b1111;
    #1;
    tick();
    check("reset_edge1", out, 1'b0);
    tick();
    check("reset_edge2", out, 1'b0);
    rst_n = 1'b1;
    #1;
    check("reset_release_no_edge", out, 1'b0);
    tick();
    check("reset_release_edge", out, 1'b1);

    // Reset with combinational output: reset invisible.
    rst_n = 1'b0; sync = 1'b0;
    #1;
    check("reset_comb_pre", out, 1'b1);
    tick();
    check("reset_comb_edge1", out, 1'b1);
    tick();
    check("reset_comb_edge2", out, 1'b1);
    sync = 1'b1;
    #1;
    check("reset_comb_q_cleared", out, 1'b0);
    rst_n = 1'b1;
    sync = 1'b0;

    // AND / OR / XOR truth tables in combinational mode.
    for (int c = 0; c < 3; c++) begin
      mem_v = cfg_tab[c];
      for (int i = 0; i < 4; i++) begin
        in_v = 2'(i);
        #1;
        check($sformatf("comb_cfg%0d_in%0d", c, i), out, 1'(exp_tab[c][i]));
      end
    end

    // Registered mode, XOR: one-cycle latency.
    sync = 1'b1; mem_v = 4'b0110; in_v = 2'b00;
    tick();
    check("reg_settle", out, 1'b0);
    in_v = 2'b01;
    #1;
    check("reg_hold_before_edge", out, 1'b0);
    tick();
    check("reg_in01_after_edge", out, 1'b1);
    in_v = 2'b11;
    #1;
    check("reg_in11_hold", out, 1'b1);
    tick();
    check("reg_in11_after_edge", out, 1'b0);

    // Mode switching with AND, in=11.
    mem_v = 4'b1000; in_v = 2'b11; sync = 1'b0;
    tick();
    check("mode_comb", out, 1'b1);
    sync = 1'b1; #1;
    check("mode_to_reg", out, 1'b1);
    sync = 1'b0; #1;
    check("mode_back_comb", out, 1'b1);
    sync = 1'b1; in_v = 2'b00; #1;
    check("mode_reg_hold", out, 1'b1);
    sync = 1'b0; #1;
    check("mode_comb_immediate", out, 1'b0);
    sync = 1'b1; #1;
    check("mode_reg_still_old", out, 1'b1);
    tick();
    check("mode_reg_after_edge", out, 1'b0);

    // Live reconfiguration with no clock.
    sync = 1'b0; in_v = 2'b10; mem_v = 4'b1000; #1;
    check("reconf_before", out, 1'b0);
    mem_v = 4'b0100; #1;
    check("reconf_after", out, 1'b1);

    // Reset and input change coinciding at an edge: reset wins.
    sync = 1'b1; mem_v = 4'b1111; in_v = 2'b01;
    tick();
    check("collide_pre", out, 1'b1);
    rst_n = 1'b0; in_v = 2'b10;
    tick();
    check("collide_reset_wins", out, 1'b0);
    rst_n = 1'b1;

    // Randomised traffic against the model.
    for (int n = 0; n < 300; n++) begin
      mem_v = 4'($urandom_range(0, 15));
      in_v  = 2'($urandom_range(0, 3));
      sync  = 1'($urandom_range(0, 1));
      rst_n = ($urandom_range(0, 7) != 0);
      #1;
      check($sformatf("rand_pre_%0d", n), out, ref_out());
      if ($urandom_range(0, 1) == 1) begin
        prev = model_q;
        tick();
        check($sformatf("rand_post_%0d", n), out, ref_out());
        if (sync) begin
          check($sformatf("rand_q_%0d", n), out, model_q);
        end else if (prev !== model_q) begin
          sync = 1'b1; #1;
          check($sformatf("rand_q_peek_%0d", n), out, model_q);
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
